// File: rtl/comp_nibble_readout.sv
// Plays captured comparator operands A/B and their comparison result back on a 4-LED bank,
// one nibble per debounced press of a raw pushbutton.
module comp_nibble_readout #(
    parameter int DEB_CYCLES = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       pb_raw,
    output logic [3:0] led,
    output logic [2:0] idx,
    output logic       valid,
    output logic       wrap
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [2:0]      r_idx;
    logic [2:0]      w_idx_nx;
    logic            w_wrap_nx;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_deb;
    logic            r_deb_d;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_a;
    logic [7:0]      r_b;
    logic            r_valid;
    logic            r_wrap;
    logic [3:0]      r_led;
    logic            w_step;
    logic            w_lt;
    logic            w_eq;
    logic            w_gt;
    logic [3:0]      w_result;

    function automatic logic [3:0] sel_nibble(input logic [2:0] sel, input logic [7:0] qa,
                                              input logic [7:0] qb, input logic [3:0] res);
        case (sel)
            3'd0:    return qa[3:0];
            3'd1:    return qa[7:4];
            3'd2:    return qb[3:0];
            3'd3:    return qb[7:4];
            3'd4:    return res;
            default: return 4'd0;
        endcase
    endfunction

    // Button synchronizer and debouncer; a level change needs DEB_CYCLES stable cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= pb_raw;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            if (r_sync2 == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Only the press edge of the debounced level advances playback
    assign w_step = r_deb & ~r_deb_d;

    // Magnitude comparison of the captured operands
    always_comb begin
        if (SIGNED_CMP) begin
            w_lt = ($signed(r_a) < $signed(r_b));
        end else begin
            w_lt = (r_a < r_b);
        end
        w_eq     = (r_a == r_b);
        w_gt     = ~w_lt & ~w_eq;
        w_result = {1'b0, w_lt, w_eq, w_gt};
    end

    // Playback next-state: load always restarts at A_lo and swallows a coincident step
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_wrap_nx  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_nx = ST_SHOW;
                    w_idx_nx   = 3'd0;
                end else begin
                    w_state_nx = ST_IDLE;
                    w_idx_nx   = 3'd7;
                end
            end
            ST_SHOW: begin
                if (load) begin
                    w_idx_nx = 3'd0;
                end else if (w_step) begin
                    if (r_idx == 3'd4) begin
                        w_idx_nx  = 3'd0;
                        w_wrap_nx = 1'b1;
                    end else begin
                        w_idx_nx = r_idx + 3'd1;
                    end
                end else begin
                    w_idx_nx = r_idx;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_idx_nx   = 3'd7;
            end
        endcase
    end

    // Playback state, operand capture and LED register (LED follows idx one cycle later)
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= 3'd7;
            r_wrap  <= 1'b0;
            r_a     <= 8'd0;
            r_b     <= 8'd0;
            r_valid <= 1'b0;
            r_led   <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_wrap  <= w_wrap_nx;
            r_led   <= sel_nibble(r_idx, r_a, r_b, w_result);
            if (load) begin
                r_a     <= a;
                r_b     <= b;
                r_valid <= 1'b1;
            end else begin
                r_a     <= r_a;
                r_b     <= r_b;
                r_valid <= r_valid;
            end
        end
    end

    assign led   = r_led;
    assign idx   = r_idx;
    assign valid = r_valid;
    assign wrap  = r_wrap;

endmodule
